mux_rr_arb: RTL and testbench

- Parametrised N-to-1 data mux that succeeds the fixed 4-to-1 combinational mux.
- Adds per-channel valid/ready handshakes, round-robin or fixed-select arbitration, and a registered output stage.
- Sits in the CPU datapath wherever several producers share one consumer, e.g. writeback-source merge or shared memory-port request selection.

---
 rtl/mux_rr_arb_pkg.sv | 15 +
 rtl/mux_rr_arb_if.sv | 46 ++++
 rtl/mux_rr_arb_rr_grant.sv | 39 +++
 rtl/mux_rr_arb.sv | 112 +++++++++++
 tb/tb_mux_rr_arb.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_arb_pkg.sv
// Shared constants for the N-to-1 round-robin/fixed-select mux and its arbiter.
// Latency: none (package only).
// Backpressure: not applicable.
// Contents: mode encodings and the select/index width helper.
package mux_rr_arb_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Index width for an n-entry channel set; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_rr_arb_if.sv
// Handshake bundle between the producers, the mux and the single consumer.
// Latency: none (wires only).
// Backpressure: carried by in_ready (mux -> producers) and out_ready (consumer -> mux).
// Signals: mode/select steer arbitration; in_data/in_valid/in_ready are per-channel;
// out_data/out_ch/out_valid/out_ready form the output handshake.
// Optional: in_last exists only when MUX_RR_LOCK_EN is defined.
interface mux_rr_arb_if
    import mux_rr_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4
);
    localparam int SEL_W = sel_w(NUM_CH);

    logic                    mode;
    logic [SEL_W-1:0]        select;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;
`ifdef MUX_RR_LOCK_EN
    logic [NUM_CH-1:0]       in_last;

    modport master (
        output mode, select, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
    modport slave (
        input  mode, select, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
`else
    modport master (
        output mode, select, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
    modport slave (
        input  mode, select, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
`endif

endinterface

// File: rtl/mux_rr_arb_rr_grant.sv
// Rotating priority encoder: first set request at or after ptr_i, wrapping N-1 -> 0.
// Latency: combinational.
// Backpressure: none; caller qualifies the grant with its own ready.
// Ports: req_i requests, ptr_i start index, gnt_o one-hot grant, idx_o grant index, any_o grant valid.
module rr_grant
    import mux_rr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = sel_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int k;

    // Walk from the farthest position back toward ptr_i so the nearest
    // requester (in rotated order) is the last one written and wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(ptr_i) + i;
            if (k >= N) k = k - N;
            if (req_i[k]) begin
                gnt_o    = '0;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arb.sv
// N-to-1 data mux with round-robin or fixed-select arbitration and a registered output slot.
// Latency: 1 cycle from input transfer to out_valid; one word per cycle while out_ready=1.
// Backpressure: in_ready is all-zero while the held word is stalled (out_valid && !out_ready).
// Ports: clk, rst (sync, active-high), bus (slave side of mux_rr_arb_if).
// Optional: MUX_RR_LOCK_EN adds in_last and locks round-robin to a channel until its last word.
module mux_rr_arb
    import mux_rr_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = sel_w(NUM_CH)
) (
    input  logic          clk,
    input  logic          rst,
    mux_rr_arb_if.slave   bus
);

    logic [WIDTH-1:0]  out_data_q;
    logic [SEL_W-1:0]  out_ch_q;
    logic              out_valid_q;
    logic [SEL_W-1:0]  ptr_q;

    logic [NUM_CH-1:0] rr_req;
    logic [NUM_CH-1:0] rr_gnt;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_any;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  gnt_idx;
    logic [NUM_CH-1:0] in_ready_w;
    logic [SEL_W-1:0]  ptr_next;
    logic              sel_ok;
    logic              accept;
    logic              xfer;

`ifdef MUX_RR_LOCK_EN
    logic              lock_q;
    logic [SEL_W-1:0]  lock_ch_q;

    // While locked only the owning channel may compete.
    assign rr_req = lock_q ? (bus.in_valid & (NUM_CH'(1) << lock_ch_q)) : bus.in_valid;
`else
    assign rr_req = bus.in_valid;
`endif

    rr_grant #(.N(NUM_CH), .IW(SEL_W)) u_rr_grant (
        .req_i (rr_req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    // Select values past the last channel (non-power-of-two NUM_CH) grant nothing.
    assign sel_ok = int'(bus.select) < NUM_CH;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        if (bus.mode == MODE_FIXED) begin
            gnt_idx = bus.select;
            if (sel_ok && bus.in_valid[bus.select]) grant[bus.select] = 1'b1;
        end else begin
            gnt_idx = rr_idx;
            if (rr_any) grant = rr_gnt;
        end
    end

    assign accept     = !out_valid_q || bus.out_ready;
    assign in_ready_w = (rst || !accept) ? '0 : grant;
    assign xfer       = |in_ready_w;
    assign ptr_next   = (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
`ifdef MUX_RR_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            if (accept) begin
                out_valid_q <= xfer;
                if (xfer) begin
                    out_data_q <= bus.in_data[int'(gnt_idx)*WIDTH +: WIDTH];
                    out_ch_q   <= gnt_idx;
                end
            end
`ifdef MUX_RR_LOCK_EN
            if (bus.mode == MODE_FIXED) begin
                lock_q <= 1'b0;
            end else if (xfer) begin
                // Pointer moves only when a burst finishes, so the next
                // search starts just past the channel that held the lock.
                lock_q    <= !bus.in_last[gnt_idx];
                lock_ch_q <= gnt_idx;
                if (bus.in_last[gnt_idx]) ptr_q <= ptr_next;
            end
`else
            if (xfer && bus.mode == MODE_RR) ptr_q <= ptr_next;
`endif
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb: reset, round-robin order, skip, fixed select,
// back-pressure and (with MUX_RR_LOCK_EN) channel lock.
// Inputs change 1 time unit after a rising edge; outputs are checked at that point.
module tb_mux_rr_arb;

    localparam int WIDTH  = 32;
    localparam int NUM_CH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mux_rr_arb_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

    mux_rr_arb #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst           = 1'b1;
        bus.mode      = 1'b0;
        bus.select    = '0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
`ifdef MUX_RR_LOCK_EN
        bus.in_last   = '1;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (bus.in_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_in_ready cyc%0d got %b want 0000", i, bus.in_ready);
            end
        end
        bus.in_valid = '0;
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_ch !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b d=%h ch=%0d want v=0 d=0 ch=0",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
    endtask

    task automatic test_rr_fair;
        logic [1:0]  exp_ch [5];
        logic [31:0] exp_d  [5];
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_d  = '{32'h5, 32'h1, 32'h4, 32'h3, 32'h5};
        reset_dut();
        bus.in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== exp_ch[i] || bus.out_data !== exp_d[i]) begin
                miscompares++;
                $display("FAIL rr_fair step%0d got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                         i, bus.out_valid, bus.out_ch, bus.out_data, exp_ch[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_rr_skip;
        logic [3:0] exp_rdy [3];
        logic [1:0] exp_ch  [3];
        exp_rdy = '{4'b0010, 4'b1000, 4'b0010};
        exp_ch  = '{2'd1, 2'd3, 2'd1};
        reset_dut();
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (bus.in_ready !== exp_rdy[i]) begin
                miscompares++;
                $display("FAIL rr_skip_ready step%0d got %b want %b", i, bus.in_ready, exp_rdy[i]);
            end
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== exp_ch[i]) begin
                miscompares++;
                $display("FAIL rr_skip_out step%0d got v=%b ch=%0d want v=1 ch=%0d",
                         i, bus.out_valid, bus.out_ch, exp_ch[i]);
            end
        end
    endtask

    task automatic test_fixed;
        reset_dut();
        bus.mode     = 1'b1;
        bus.select   = 2'd2;
        bus.in_valid = 4'hF;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h4 || bus.out_ch !== 2'd2) begin
            miscompares++;
            $display("FAIL fixed_sel2 got v=%b d=%h ch=%0d want v=1 d=4 ch=2",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        bus.select = 2'd3;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3 || bus.out_ch !== 2'd3) begin
            miscompares++;
            $display("FAIL fixed_sel3 got v=%b d=%h ch=%0d want v=1 d=3 ch=3",
                     bus.out_valid, bus.out_data, bus.out_ch);
        end
        bus.select   = 2'd2;
        bus.in_valid = 4'b1011;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL fixed_nogrant_ready got %b want 0000", bus.in_ready);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fixed_nogrant_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure;
        reset_dut();
        bus.in_valid = 4'hF;
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (bus.in_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL bp_ready cyc%0d got %b want 0000", i, bus.in_ready);
            end
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_data !== 32'h5) begin
                miscompares++;
                $display("FAIL bp_hold cyc%0d got v=%b ch=%0d d=%h want v=1 ch=0 d=5",
                         i, bus.out_valid, bus.out_ch, bus.out_data);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL bp_release_ready got %b want 0010", bus.in_ready);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1 || bus.out_data !== 32'h1) begin
            miscompares++;
            $display("FAIL bp_refill got v=%b ch=%0d d=%h want v=1 ch=1 d=1",
                     bus.out_valid, bus.out_ch, bus.out_data);
        end
    endtask

`ifdef MUX_RR_LOCK_EN
    task automatic test_lock;
        logic [1:0] exp_ch [5];
        logic [3:0] last_v [5];
        exp_ch = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
        last_v = '{4'b1111, 4'b0101, 4'b0101, 4'b0111, 4'b0111};
        reset_dut();
        // First word from ch0 alone moves the pointer to ch1.
        bus.in_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            bus.in_last = last_v[i];
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_ch !== exp_ch[i]) begin
                miscompares++;
                $display("FAIL lock step%0d got v=%b ch=%0d want v=1 ch=%0d",
                         i, bus.out_valid, bus.out_ch, exp_ch[i]);
            end
            bus.in_valid = 4'b0111;
        end
    endtask
`endif

    initial begin
        bus.mode      = 1'b0;
        bus.select    = '0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        bus.in_data   = {32'h3, 32'h4, 32'h1, 32'h5};
`ifdef MUX_RR_LOCK_EN
        bus.in_last   = '1;
`endif
        #1;
        test_reset();
        test_rr_fair();
        test_rr_skip();
        test_fixed();
        test_backpressure();
`ifdef MUX_RR_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
